// File: rtl/seek_pkg.sv
// Shared constants, FSM state type and the mm:ss-to-seconds helper for the
// seek controller.
package seek_pkg;

  localparam int SECS_PER_MIN = 60;
  localparam int TGT_W        = 15;   // seconds, up to 511:59
  localparam int PROD_W       = 34;   // seconds x bytes-per-second
  localparam int MCAND_W      = 18;   // bytes-per-second operand width

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    CLAMP,
    MUL,
    ADD,
    REQ
  } seek_state_e;

  // minutes*60 + seconds, with x60 done as (x<<6)-(x<<2) to avoid a multiplier
  function automatic logic [TGT_W-1:0] mmss_to_sec(input logic [8:0] m,
                                                   input logic [5:0] s);
    logic [TGT_W-1:0] w_m;
    w_m = {6'd0, m};
    return (w_m << 6) - (w_m << 2) + {9'd0, s};
  endfunction

endpackage

// File: rtl/seq_shift_mult.sv
// Sequential shift-add multiplier: 15-bit i_a times 18-bit i_b, one multiplier
// bit per clock, LSB first. Bit 0 is folded into the start clock, so o_done
// pulses on the clock after the 15th partial product has been added.
module seq_shift_mult
  import seek_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [TGT_W-1:0]   i_a,
  input  logic [MCAND_W-1:0] i_b,
  output logic [PROD_W-1:0]  o_product,
  output logic               o_done
);

  logic [TGT_W-1:0]  r_mplier;
  logic [PROD_W-1:0] r_mcand;
  logic [PROD_W-1:0] r_acc;
  logic [3:0]        r_cnt;
  logic              r_run;
  logic              r_done;

  // Load on start (handling bit 0), then add one shifted partial product per clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_mplier <= i_a >> 1;
        r_mcand  <= PROD_W'(i_b) << 1;
        r_acc    <= i_a[0] ? PROD_W'(i_b) : '0;
        r_cnt    <= 4'd1;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mplier <= r_mplier >> 1;
        r_mcand  <= r_mcand << 1;
        r_cnt    <= r_cnt + 4'd1;
        if (r_cnt == 4'(TGT_W - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_product = r_acc;
  assign o_done    = r_done;

endmodule

// File: rtl/seek_controller.sv
// Seek controller: turns a user mm:ss target into a byte address and issues it
// over seek_req/seek_ack. Targets past the end of the track are clamped to the
// last second; one newer request is queued while busy.
// Handshake: seek_req rises with seek_addr/clamped valid and holds them until
// the first clock seek_ack is sampled high; seek_ack is ignored outside REQ.
// Optional macro SEEK_TIMEOUT_EN adds an ack timeout of TIMEOUT_CYC clocks.
module seek_controller
  import seek_pkg::*;
#(
  parameter int unsigned BYTES_PER_SEC = 192000,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned TIMEOUT_CYC   = 1048576
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              modify,
  input  logic [8:0]        min_mod,
  input  logic [5:0]        sec_mod,
  input  logic [8:0]        minute_n,
  input  logic [5:0]        second_n,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              seek_req,
  output logic [ADDR_W-1:0] seek_addr,
  input  logic              seek_ack,
  output logic              busy,
  output logic              seek_done,
  output logic              seek_err,
  output logic              clamped,
  output seek_state_e       dbg_state
);

  localparam int SUM_W = ((ADDR_W > PROD_W) ? ADDR_W : PROD_W) + 1;

  seek_state_e       r_state;
  logic              r_modify_d;
  logic [8:0]        r_min, r_mn, r_pmin, r_pmn;
  logic [5:0]        r_sec, r_sn, r_psec, r_psn;
  logic [ADDR_W-1:0] r_base, r_pbase;
  logic              r_pending;
  logic [TGT_W-1:0]  r_tgt, r_len;
  logic              r_mul_start;
  logic              w_mul_done;
  logic [PROD_W-1:0] w_product;
  logic [SUM_W-1:0]  w_sum;
  logic              w_ovf;
  logic              w_rise;
  logic              w_end;
  logic              w_timeout;
`ifdef SEEK_TIMEOUT_EN
  logic [20:0]       r_to_cnt;
`endif

  seq_shift_mult u_mult (
    .i_clk     (sys_clk),
    .i_rst_n   (rst_n),
    .i_start   (r_mul_start),
    .i_a       (r_tgt),
    .i_b       (MCAND_W'(BYTES_PER_SEC)),
    .o_product (w_product),
    .o_done    (w_mul_done)
  );

  assign w_rise    = modify & ~r_modify_d;
  assign w_sum     = SUM_W'(r_base) + SUM_W'(w_product);
  assign w_ovf     = |w_sum[SUM_W-1:ADDR_W];
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

  // Terminal clocks of a request: empty track, address overflow, ack or timeout
  always_comb begin
    w_timeout = 1'b0;
`ifdef SEEK_TIMEOUT_EN
    w_timeout = (r_state == REQ) && !seek_ack &&
                (r_to_cnt == 21'(TIMEOUT_CYC - 1));
`endif
    case (r_state)
      CLAMP:   w_end = (r_len == '0);
      ADD:     w_end = w_ovf;
      REQ:     w_end = seek_ack | w_timeout;
      default: w_end = 1'b0;
    endcase
  end

  // Main FSM with capture/pending registers and registered handshake outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_modify_d  <= 1'b0;
      r_min       <= '0;
      r_sec       <= '0;
      r_mn        <= '0;
      r_sn        <= '0;
      r_base      <= '0;
      r_pmin      <= '0;
      r_psec      <= '0;
      r_pmn       <= '0;
      r_psn       <= '0;
      r_pbase     <= '0;
      r_pending   <= 1'b0;
      r_tgt       <= '0;
      r_len       <= '0;
      r_mul_start <= 1'b0;
      seek_req    <= 1'b0;
      seek_addr   <= '0;
      seek_done   <= 1'b0;
      seek_err    <= 1'b0;
      clamped     <= 1'b0;
`ifdef SEEK_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_modify_d  <= modify;
      seek_done   <= 1'b0;
      seek_err    <= 1'b0;
      r_mul_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_min   <= min_mod;
            r_sec   <= sec_mod;
            r_mn    <= minute_n;
            r_sn    <= second_n;
            r_base  <= base_addr;
            r_state <= SUM;
          end
        end
        SUM: begin
          r_tgt   <= mmss_to_sec(r_min, r_sec);
          r_len   <= mmss_to_sec(r_mn, r_sn);
          r_state <= CLAMP;
        end
        CLAMP: begin
          if (r_len == '0) begin
            seek_err <= 1'b1;
          end else begin
            if (r_tgt >= r_len) begin
              r_tgt   <= r_len - 1'b1;
              clamped <= 1'b1;
            end else begin
              clamped <= 1'b0;
            end
            r_mul_start <= 1'b1;
            r_state     <= MUL;
          end
        end
        MUL: begin
          if (w_mul_done) r_state <= ADD;
        end
        ADD: begin
          if (w_ovf) begin
            seek_err <= 1'b1;
          end else begin
            seek_addr <= w_sum[ADDR_W-1:0];
            seek_req  <= 1'b1;
            r_state   <= REQ;
`ifdef SEEK_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        REQ: begin
          if (seek_ack) begin
            seek_req  <= 1'b0;
            seek_done <= 1'b1;
          end
`ifdef SEEK_TIMEOUT_EN
          else if (w_timeout) begin
            seek_req <= 1'b0;
            seek_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 21'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase

      // On a terminal clock launch the newest queued target (a rise this
      // clock is newer than the pending one), otherwise return to IDLE.
      // Mid-request rises only refresh the pending slot.
      if (w_end) begin
        r_pending <= 1'b0;
        if (w_rise) begin
          r_min   <= min_mod;
          r_sec   <= sec_mod;
          r_mn    <= minute_n;
          r_sn    <= second_n;
          r_base  <= base_addr;
          r_state <= SUM;
        end else if (r_pending) begin
          r_min   <= r_pmin;
          r_sec   <= r_psec;
          r_mn    <= r_pmn;
          r_sn    <= r_psn;
          r_base  <= r_pbase;
          r_state <= SUM;
        end else begin
          r_state <= IDLE;
        end
      end else if (w_rise && r_state != IDLE) begin
        r_pmin    <= min_mod;
        r_psec    <= sec_mod;
        r_pmn     <= minute_n;
        r_psn     <= second_n;
        r_pbase   <= base_addr;
        r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seek_controller.sv
// Directed bench for seek_controller: plain seek, clamp, empty track, address
// overflow, pending/overwrite, rise on the ack clock, async reset and the
// no-ack behaviour (timeout when SEEK_TIMEOUT_EN is defined).
module tb_seek_controller;
  import seek_pkg::*;

`ifdef SEEK_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1048576;
`endif
  localparam logic [31:0] BPS = 32'd192000;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        modify = 1'b0;
  logic [8:0]  min_mod = '0;
  logic [5:0]  sec_mod = '0;
  logic [8:0]  minute_n = '0;
  logic [5:0]  second_n = '0;
  logic [31:0] base_addr = '0;
  logic        seek_ack = 1'b0;
  logic        seek_req, busy, seek_done, seek_err, clamped;
  logic [31:0] seek_addr;
  seek_state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;

  seek_controller #(
    .BYTES_PER_SEC (192000),
    .ADDR_W        (32),
    .TIMEOUT_CYC   (TB_TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .modify    (modify),
    .min_mod   (min_mod),
    .sec_mod   (sec_mod),
    .minute_n  (minute_n),
    .second_n  (second_n),
    .base_addr (base_addr),
    .seek_req  (seek_req),
    .seek_addr (seek_addr),
    .seek_ack  (seek_ack),
    .busy      (busy),
    .seek_done (seek_done),
    .seek_err  (seek_err),
    .clamped   (clamped),
    .dbg_state (dbg_state)
  );

  // 50 MHz clock
  always #10 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One-clock modify pulse at a negedge; returns one negedge after the rise edge
  task automatic pulse_modify(input logic [8:0] m, input logic [5:0] s);
    min_mod = m; sec_mod = s; modify = 1'b1;
    tick(1);
    modify = 1'b0;
  endtask

  task automatic ack_one();
    seek_ack = 1'b1;
    tick(1);
    seek_ack = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_vec++; if (seek_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", seek_req); end
    n_vec++; if (seek_addr !== 32'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", seek_addr); end
    n_vec++; if ({busy, seek_done, seek_err, clamped} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {busy, seek_done, seek_err, clamped}); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_plain_seek();
    logic [31:0] exp;
    exp = 32'h1000 + 32'd90 * BPS;
    minute_n = 9'd3; second_n = 6'd0; base_addr = 32'h1000;
    min_mod = 9'd1; sec_mod = 6'd30; modify = 1'b1;
    tick(1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL plain_busy: got %0b want 1", busy); end
    tick(2); modify = 1'b0;
    tick(16);
    n_vec++; if (seek_req !== 1'b0) begin n_err++; $display("FAIL plain_req_early: got %0b want 0", seek_req); end
    tick(1);
    n_vec++; if (seek_req !== 1'b1) begin n_err++; $display("FAIL plain_req_t19: got %0b want 1", seek_req); end
    n_vec++; if (seek_addr !== exp) begin n_err++; $display("FAIL plain_addr: got %h want %h", seek_addr, exp); end
    n_vec++; if (clamped !== 1'b0) begin n_err++; $display("FAIL plain_clamped: got %0b want 0", clamped); end
    tick(3);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== exp) begin n_err++; $display("FAIL plain_hold: req %0b addr %h want 1 %h", seek_req, seek_addr, exp); end
    seek_ack = 1'b1;
    tick(1);
    n_vec++; if ({seek_req, seek_done, busy} !== 3'b010) begin n_err++; $display("FAIL plain_done: req/done/busy %b want 010", {seek_req, seek_done, busy}); end
    seek_ack = 1'b0;
    tick(1);
    n_vec++; if (seek_done !== 1'b0) begin n_err++; $display("FAIL plain_done_pulse: got %0b want 0", seek_done); end
  endtask

  task automatic test_clamp();
    logic [31:0] exp;
    exp = 32'h0020_0000 + 32'd124 * BPS;
    minute_n = 9'd2; second_n = 6'd5; base_addr = 32'h0020_0000;
    pulse_modify(9'd7, 6'd0);
    tick(4);
    seek_ack = 1'b1;              // held early: must be ignored until REQ
    tick(5);
    n_vec++; if (busy !== 1'b1 || seek_done !== 1'b0) begin n_err++; $display("FAIL clamp_ack_ignored: busy %0b done %0b want 1 0", busy, seek_done); end
    tick(10);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== exp) begin n_err++; $display("FAIL clamp_addr: req %0b addr %h want 1 %h", seek_req, seek_addr, exp); end
    n_vec++; if (clamped !== 1'b1) begin n_err++; $display("FAIL clamp_flag: got %0b want 1", clamped); end
    tick(1);
    n_vec++; if ({seek_req, seek_done} !== 2'b01) begin n_err++; $display("FAIL clamp_first_req_ack: req/done %b want 01", {seek_req, seek_done}); end
    seek_ack = 1'b0;
    tick(2);
  endtask

  task automatic test_empty_track();
    int bad;
    minute_n = 9'd0; second_n = 6'd0; base_addr = 32'h0;
    pulse_modify(9'd1, 6'd0);
    tick(1);
    n_vec++; if (seek_err !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL empty_pre: err %0b busy %0b want 0 1", seek_err, busy); end
    tick(1);
    n_vec++; if (seek_err !== 1'b1) begin n_err++; $display("FAIL empty_err: got %0b want 1", seek_err); end
    tick(1);
    n_vec++; if (busy !== 1'b0 || seek_err !== 1'b0) begin n_err++; $display("FAIL empty_idle: busy %0b err %0b want 0 0", busy, seek_err); end
    bad = 0;
    for (int i = 0; i < 25; i++) begin tick(1); if (seek_req !== 1'b0) bad++; end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL empty_no_req: %0d cycles with req want 0", bad); end
  endtask

  task automatic test_overflow();
    minute_n = 9'd3; second_n = 6'd0; base_addr = 32'hFFFF_0000;
    pulse_modify(9'd1, 6'd0);
    tick(19);
    n_vec++; if (seek_err !== 1'b1 || seek_req !== 1'b0) begin n_err++; $display("FAIL ovf_err: err %0b req %0b want 1 0", seek_err, seek_req); end
    tick(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_idle: busy %0b want 0", busy); end
  endtask

  task automatic test_pending();
    logic [31:0] b;
    b = 32'h0040_0000;
    minute_n = 9'd3; second_n = 6'd0; base_addr = b;
    pulse_modify(9'd0, 6'd20);
    tick(7);
    pulse_modify(9'd0, 6'd10);    // during MUL of the first request
    tick(11);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== b + 32'd20 * BPS) begin n_err++; $display("FAIL pend_first: req %0b addr %h want 1 %h", seek_req, seek_addr, b + 32'd20 * BPS); end
    tick(2);
    seek_ack = 1'b1;
    tick(1);
    n_vec++; if ({seek_req, seek_done, busy} !== 3'b011) begin n_err++; $display("FAIL pend_done: req/done/busy %b want 011", {seek_req, seek_done, busy}); end
    seek_ack = 1'b0;
    tick(18);
    n_vec++; if (seek_req !== 1'b0) begin n_err++; $display("FAIL pend_req_early: got %0b want 0", seek_req); end
    tick(1);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== b + 32'd1920000) begin n_err++; $display("FAIL pend_second: req %0b addr %h want 1 %h", seek_req, seek_addr, b + 32'd1920000); end
    seek_ack = 1'b1;
    tick(1);
    seek_ack = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pend_idle: busy %0b want 0", busy); end
    tick(1);
  endtask

  task automatic test_pending_overwrite();
    logic [31:0] b;
    b = 32'h0080_0000;
    base_addr = b;
    pulse_modify(9'd0, 6'd20);
    tick(7);
    pulse_modify(9'd0, 6'd10);
    tick(12);
    pulse_modify(9'd0, 6'd5);     // in REQ, before the ack
    tick(2);
    seek_ack = 1'b1;
    tick(1);
    seek_ack = 1'b0;
    n_vec++; if (seek_done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ovw_done: done %0b busy %0b want 1 1", seek_done, busy); end
    tick(19);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== b + 32'd960000) begin n_err++; $display("FAIL ovw_addr: req %0b addr %h want 1 %h", seek_req, seek_addr, b + 32'd960000); end
    ack_one();
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    b = 32'h0100_0000;
    base_addr = b;
    pulse_modify(9'd0, 6'd30);
    tick(19);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== b + 32'd30 * BPS) begin n_err++; $display("FAIL b2b_first: req %0b addr %h want 1 %h", seek_req, seek_addr, b + 32'd30 * BPS); end
    seek_ack = 1'b1; min_mod = 9'd0; sec_mod = 6'd40; modify = 1'b1;
    tick(1);
    seek_ack = 1'b0; modify = 1'b0;
    n_vec++; if (seek_done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_done: done %0b busy %0b want 1 1", seek_done, busy); end
    tick(19);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== b + 32'd40 * BPS) begin n_err++; $display("FAIL b2b_second: req %0b addr %h want 1 %h", seek_req, seek_addr, b + 32'd40 * BPS); end
    ack_one();
  endtask

  task automatic test_reset_mid_req();
    int bad;
    base_addr = 32'h0;
    pulse_modify(9'd1, 6'd0);
    tick(19);
    n_vec++; if (seek_req !== 1'b1) begin n_err++; $display("FAIL rmr_req: got %0b want 1", seek_req); end
    pulse_modify(9'd0, 6'd50);    // leaves a pending request behind
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (seek_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmr_async: req %0b busy %0b want 0 0", seek_req, busy); end
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin tick(1); if (seek_req !== 1'b0 || busy !== 1'b0) bad++; end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rmr_quiet: %0d active cycles want 0", bad); end
    pulse_modify(9'd0, 6'd15);
    tick(19);
    n_vec++; if (seek_req !== 1'b1 || seek_addr !== 32'd15 * BPS) begin n_err++; $display("FAIL rmr_fresh: req %0b addr %h want 1 %h", seek_req, seek_addr, 32'd15 * BPS); end
    ack_one();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmr_pend_cleared: busy %0b want 0", busy); end
  endtask

  task automatic test_no_ack();
    int bad;
    base_addr = 32'h0;
    pulse_modify(9'd0, 6'd5);
    tick(19);
`ifdef SEEK_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 16; i++) begin if (seek_req !== 1'b1) bad++; if (i < 15) tick(1); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL to_hold: %0d low cycles want 0", bad); end
    tick(1);
    n_vec++; if (seek_req !== 1'b0 || seek_err !== 1'b1) begin n_err++; $display("FAIL to_err: req %0b err %0b want 0 1", seek_req, seek_err); end
    tick(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle: busy %0b want 0", busy); end
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin if (seek_req !== 1'b1 || seek_err !== 1'b0) bad++; tick(1); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL noack_hold: %0d bad cycles want 0", bad); end
    ack_one();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL noack_release: busy %0b want 0", busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_plain_seek();
    test_clamp();
    test_empty_track();
    test_overflow();
    test_pending();
    test_pending_overwrite();
    test_back_to_back();
    test_reset_mid_req();
    test_no_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
